// File: rtl/wishbone_config_loader.sv
// rtl/wishbone_config_loader.sv - Wishbone classic initiator streaming config words to sequential addresses
module wishbone_config_loader #(
    parameter logic [31:0] ADDR_STEP      = 32'd4,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          CNT_W          = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [31:0]      base_addr_i,
    input  logic [CNT_W-1:0] word_count_i,
    input  logic [31:0]      cfg_data_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic             wbm_ack_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o,
    output logic [CNT_W-1:0] words_done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    // Counter only needs to hold 0..TIMEOUT_CYCLES-1; the last value triggers the timeout.
    localparam int             TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]  TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit             TMO_EN   = (TIMEOUT_CYCLES > 0);

    state_t           state;
    logic             cyc_q;
    logic             ready_q;
    logic             done_q;
    logic             error_q;
    logic [31:0]      adr_q;
    logic [31:0]      dat_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] words_q;
    logic [TW-1:0]    tmo_q;
    logic [CNT_W-1:0] words_next;
    logic             abort_ok;

    assign words_next = words_q + 1'b1;
    assign abort_ok   = abort_i && (state != S_IDLE) && (state != S_DONE);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state   <= S_IDLE;
            cyc_q   <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            count_q <= '0;
            words_q <= '0;
            tmo_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort_ok) begin
                state   <= S_ERR;
                cyc_q   <= 1'b0;
                ready_q <= 1'b0;
                error_q <= 1'b1;
            end else begin
                case (state)
                    S_IDLE, S_DONE, S_ERR: begin
                        if (start_i) begin
                            adr_q   <= base_addr_i;
                            count_q <= word_count_i;
                            words_q <= '0;
                            error_q <= 1'b0;
                            if (word_count_i == '0) begin
                                state  <= S_DONE;
                                done_q <= 1'b1;
                            end else begin
                                state   <= S_FETCH;
                                ready_q <= 1'b1;
                            end
                        end else if (state == S_DONE) begin
                            state <= S_IDLE;
                        end
                    end
                    S_FETCH: begin
                        if (cfg_valid_i) begin
                            dat_q   <= cfg_data_i;
                            state   <= S_WRITE;
                            ready_q <= 1'b0;
                            cyc_q   <= 1'b1;
                            tmo_q   <= '0;
                        end
                    end
                    S_WRITE: begin
                        // An ack in the timeout cycle still completes the write.
                        if (wbm_ack_i) begin
                            cyc_q   <= 1'b0;
                            words_q <= words_next;
                            adr_q   <= adr_q + ADDR_STEP;
                            if (words_next == count_q) begin
                                state  <= S_DONE;
                                done_q <= 1'b1;
                            end else begin
                                state   <= S_FETCH;
                                ready_q <= 1'b1;
                            end
                        end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
                            cyc_q   <= 1'b0;
                            error_q <= 1'b1;
                            state   <= S_ERR;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign cfg_ready_o  = ready_q;
    assign wbm_cyc_o    = cyc_q;
    assign wbm_stb_o    = cyc_q;
    assign wbm_we_o     = cyc_q;
    assign wbm_sel_o    = {4{cyc_q}};
    assign wbm_adr_o    = adr_q;
    assign wbm_dat_o    = dat_q;
    assign busy_o       = (state == S_FETCH) || (state == S_WRITE);
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign words_done_o = words_q;

endmodule

// File: tb/tb_wishbone_config_loader.sv
// tb/tb_wishbone_config_loader.sv - directed self-checking bench for wishbone_config_loader
module tb_wishbone_config_loader;

    localparam int CNT_W = 16;
    localparam int NEVER = 1000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_i = 1'b0;
    logic             abort_i = 1'b0;
    logic [31:0]      base_addr_i = '0;
    logic [CNT_W-1:0] word_count_i = '0;
    logic [31:0]      cfg_data_i = '0;
    logic             cfg_valid_i = 1'b0;
    logic             cfg_ready_o;
    logic             wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]       wbm_sel_o;
    logic [31:0]      wbm_adr_o, wbm_dat_o;
    logic             wbm_ack_i;
    logic             busy_o, done_o, error_o;
    logic [CNT_W-1:0] words_done_o;

    logic tb_ack = 1'b0;
    logic slv_ack = 1'b0;
    assign wbm_ack_i = tb_ack | slv_ack;

    always #5 clk = ~clk;

    wishbone_config_loader #(
        .ADDR_STEP     (32'd4),
        .TIMEOUT_CYCLES(8),
        .CNT_W         (CNT_W)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .base_addr_i (base_addr_i),
        .word_count_i(word_count_i),
        .cfg_data_i  (cfg_data_i),
        .cfg_valid_i (cfg_valid_i),
        .cfg_ready_o (cfg_ready_o),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_ack_i   (wbm_ack_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .error_o     (error_o),
        .words_done_o(words_done_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Slave model: per-write ack delay plan, records acked writes, checks stability during stb.
    int          plan[$];
    int          cur_delay = 0;
    int          stb_len = 0;
    int          last_len = 0;
    logic [31:0] cap_adr = '0, cap_dat = '0;
    logic [3:0]  cap_sel = '0;
    logic [31:0] rec_adr[$], rec_dat[$];
    bit          track_wd = 1'b0;
    int          job_acks = 0;

    initial begin
        forever begin
            tick();
            if (slv_ack) begin
                rec_adr.push_back(cap_adr);
                rec_dat.push_back(cap_dat);
                check_eq("sel", 32'(cap_sel), 32'hF);
                job_acks++;
            end
            if (track_wd) check_eq("wd_vs_ack", 32'(words_done_o), job_acks);
            if (wbm_stb_o) begin
                check_eq("we_eq_stb", 32'(wbm_we_o), 32'd1);
                if (stb_len == 0) begin
                    if (plan.size() > 0) cur_delay = plan.pop_front();
                    else cur_delay = 0;
                    cap_adr = wbm_adr_o;
                    cap_dat = wbm_dat_o;
                    cap_sel = wbm_sel_o;
                end else begin
                    check_eq("adr_stable", wbm_adr_o, cap_adr);
                    check_eq("dat_stable", wbm_dat_o, cap_dat);
                end
                stb_len++;
                slv_ack = (stb_len - 1 == cur_delay);
            end else begin
                if (stb_len != 0) last_len = stb_len;
                stb_len = 0;
                slv_ack = 1'b0;
            end
        end
    end

    // Source model: presents queued words, optionally gapping valid after each handshake.
    logic [31:0] src_q[$];
    int          src_gap = 0;
    int          gap_cnt = 0;
    bit          prev_ready = 1'b0;

    initial begin
        forever begin
            tick();
            if (cfg_valid_i && prev_ready) begin
                void'(src_q.pop_front());
                gap_cnt = src_gap;
            end
            prev_ready = cfg_ready_o;
            if (gap_cnt > 0) begin
                cfg_valid_i = 1'b0;
                gap_cnt--;
            end else if (src_q.size() > 0) begin
                cfg_valid_i = 1'b1;
                cfg_data_i  = src_q[0];
            end else begin
                cfg_valid_i = 1'b0;
            end
        end
    end

    task automatic start_job(input logic [31:0] base, input int cnt);
        base_addr_i  = base;
        word_count_i = CNT_W'(cnt);
        start_i      = 1'b1;
        tick();
        start_i      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, output int n);
        n = 0;
        while (done_o !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check_eq({tag, "_done_seen"}, 32'(done_o), 32'd1);
    endtask

    task automatic check_recs(input string tag, input logic [31:0] adr[3], input logic [31:0] dat[3], input int num);
        check_eq({tag, "_nrec"}, rec_adr.size(), num);
        for (int i = 0; i < num; i++) begin
            check_eq($sformatf("%s_adr%0d", tag, i), (i < rec_adr.size()) ? rec_adr[i] : 32'hBAD0BAD0, adr[i]);
            check_eq($sformatf("%s_dat%0d", tag, i), (i < rec_dat.size()) ? rec_dat[i] : 32'hBAD0BAD0, dat[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [31:0] ea[3];
        logic [31:0] ed[3];

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cyc", 32'(wbm_cyc_o), 0);
        check_eq("rst_done", 32'(done_o), 0);
        check_eq("rst_err", 32'(error_o), 0);
        check_eq("rst_ready", 32'(cfg_ready_o), 0);
        check_eq("rst_adr", wbm_adr_o, 0);
        rst_n = 1'b1;
        tick();

        // Reset asserted mid-WRITE
        plan = '{NEVER};
        src_q.push_back(32'hDEAD0001);
        tick();
        start_job(32'h5000_0000, 1);
        n = 0;
        while (wbm_cyc_o !== 1'b1 && n < 20) begin tick(); n++; end
        check_eq("rw_cyc_up", 32'(wbm_cyc_o), 1);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rw_cyc", 32'(wbm_cyc_o), 0);
        check_eq("rw_stb", 32'(wbm_stb_o), 0);
        check_eq("rw_done", 32'(done_o), 0);
        check_eq("rw_err", 32'(error_o), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        plan.delete();
        tick();
        check_eq("rw_idle", 32'(busy_o), 0);
        tb_ack = 1'b1;
        tick();
        tb_ack = 1'b0;
        tick();
        check_eq("idle_ack_wd", 32'(words_done_o), 0);
        check_eq("idle_ack_cyc", 32'(wbm_cyc_o), 0);

        // Basic load, zero-wait ack
        rec_adr.delete(); rec_dat.delete();
        plan = '{0, 0, 0};
        src_q.push_back(32'hA1); src_q.push_back(32'hB2); src_q.push_back(32'hC3);
        tick();
        start_job(32'h3000_0000, 3);
        wait_done("basic", 50, n);
        check_eq("basic_latency", n, 6);
        check_eq("basic_wd", 32'(words_done_o), 3);
        tick();
        check_eq("basic_done_pulse", 32'(done_o), 0);
        check_eq("basic_idle", 32'(busy_o), 0);
        ea = '{32'h3000_0000, 32'h3000_0004, 32'h3000_0008};
        ed = '{32'hA1, 32'hB2, 32'hC3};
        check_recs("basic", ea, ed, 3);

        // Backpressure: valid gapped 5 cycles, ack delayed 3 cycles
        rec_adr.delete(); rec_dat.delete();
        plan = '{3, 3, 3};
        src_gap = 5;
        src_q.push_back(32'h1111_0001); src_q.push_back(32'h2222_0002); src_q.push_back(32'h3333_0003);
        tick();
        start_job(32'h1000_0000, 3);
        job_acks = 0;
        track_wd = 1'b1;
        wait_done("bp", 200, n);
        track_wd = 1'b0;
        src_gap = 0;
        check_eq("bp_wd", 32'(words_done_o), 3);
        check_eq("bp_stb_len", last_len, 4);
        ea = '{32'h1000_0000, 32'h1000_0004, 32'h1000_0008};
        ed = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
        check_recs("bp", ea, ed, 3);

        // Timeout on the second write
        rec_adr.delete(); rec_dat.delete();
        plan = '{0, NEVER};
        src_q.push_back(32'h0000_00AA); src_q.push_back(32'h0000_00BB);
        tick();
        start_job(32'h2000_0000, 2);
        n = 0;
        while (error_o !== 1'b1 && n < 100) begin tick(); n++; end
        check_eq("tmo_err", 32'(error_o), 1);
        tick();
        check_eq("tmo_stb_len", last_len, 8);
        check_eq("tmo_wd", 32'(words_done_o), 1);
        check_eq("tmo_cyc", 32'(wbm_cyc_o), 0);
        check_eq("tmo_busy", 32'(busy_o), 0);
        check_eq("tmo_nrec", rec_adr.size(), 1);
        tick();
        check_eq("tmo_err_held", 32'(error_o), 1);
        start_job(32'h0, 0);
        check_eq("restart_err_clr", 32'(error_o), 0);
        check_eq("cnt0_done", 32'(done_o), 1);
        check_eq("cnt0_cyc", 32'(wbm_cyc_o), 0);
        tick();
        check_eq("cnt0_done_low", 32'(done_o), 0);
        check_eq("cnt0_cyc2", 32'(wbm_cyc_o), 0);

        // Abort in IDLE has no effect
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        tick();
        check_eq("idle_abort_err", 32'(error_o), 0);
        check_eq("idle_abort_busy", 32'(busy_o), 0);

        // Abort in the same cycle as ack
        plan = '{0, NEVER};
        src_q.push_back(32'h0000_0011); src_q.push_back(32'h0000_0022);
        tick();
        start_job(32'h4000_0000, 2);
        n = 0;
        while (!(words_done_o == 1 && wbm_cyc_o === 1'b1) && n < 50) begin tick(); n++; end
        check_eq("ab_second_write", 32'(wbm_cyc_o), 1);
        abort_i = 1'b1;
        tb_ack = 1'b1;
        tick();
        abort_i = 1'b0;
        tb_ack = 1'b0;
        check_eq("ab_err", 32'(error_o), 1);
        check_eq("ab_cyc", 32'(wbm_cyc_o), 0);
        check_eq("ab_wd", 32'(words_done_o), 1);
        check_eq("ab_busy", 32'(busy_o), 0);
        tick();
        check_eq("ab_err_held", 32'(error_o), 1);
        check_eq("ab_wd_held", 32'(words_done_o), 1);

        // Address wrap
        rec_adr.delete(); rec_dat.delete();
        plan = '{0, 0};
        src_q.push_back(32'h0000_0077); src_q.push_back(32'h0000_0088);
        tick();
        start_job(32'hFFFF_FFFC, 2);
        check_eq("wrap_err_clr", 32'(error_o), 0);
        wait_done("wrap", 50, n);
        ea = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0};
        ed = '{32'h77, 32'h88, 32'h0};
        check_recs("wrap", ea, ed, 2);
        check_eq("wrap_adr_next", wbm_adr_o, 32'h0000_0004);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wishbone_config_loader.md
Name: wishbone_config_loader

Overview:
- Wishbone classic initiator that streams a configuration bitstream into the fpga250 configuration slave port (wbs_* interface).
- Accepts 32-bit words on a valid/ready stream and issues one single-beat write per word to sequential addresses.
- Includes an ack timeout, an abort input and status reporting.
- Sits on the management or test side of the Wishbone bus and drives the same cyc/stb/we/sel/adr/dat signals that the fpga core consumes.

Parameters:
- ADDR_STEP, 4: byte increment applied to the address after each acknowledged write.
- TIMEOUT_CYCLES, 255: maximum number of cycles to wait for wbm_ack_i per transfer; 0 disables the timeout.
- CNT_W, 16: width of the word-count and progress counters.

Ports:
- wb_clk_i  in  1  bus clock; all logic is rising-edge.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- start_i  in  1  single-cycle launch request; sampled only in IDLE, DONE or ERR.
- abort_i  in  1  terminates the job immediately.
- base_addr_i  in  32  first write address; latched on start.
- word_count_i  in  CNT_W  number of words in the job; latched on start.
- cfg_data_i  in  32  bitstream word.
- cfg_valid_i  in  1  cfg_data_i is valid.
- cfg_ready_o  out  1  loader accepts a word this cycle.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  write enable; equals wbm_stb_o.
- wbm_sel_o  out  4  byte selects; 4'hF during a transfer, otherwise 0.
- wbm_adr_o  out  32  write address.
- wbm_dat_o  out  32  write data.
- wbm_ack_i  in  1  slave acknowledge.
- busy_o  out  1  high in FETCH or WRITE.
- done_o  out  1  one-cycle pulse on successful completion.
- error_o  out  1  sticky error flag; cleared by the next accepted start.
- words_done_o  out  CNT_W  count of acknowledged writes in the current job.

Behaviour:
- Reset values: every output 0; FSM in IDLE; address, data and counters cleared.
- FSM states: IDLE, FETCH, WRITE, DONE, ERR.
- IDLE / DONE / ERR + start_i:
  - Latch base_addr_i and word_count_i; clear words_done_o and error_o.
  - If word_count_i == 0, go to DONE and pulse done_o the next cycle with no bus activity.
  - Otherwise go to FETCH.
- FETCH:
  - cfg_ready_o = 1.
  - On cfg_valid_i & cfg_ready_o, capture the data and go to WRITE; wbm_cyc_o, wbm_stb_o and wbm_we_o rise on the next cycle.
  - cfg_ready_o is 0 in every other state.
- WRITE:
  - cyc, stb, we and sel stay asserted, with adr and dat held stable, until wbm_ack_i is seen.
  - On ack:
    - Deassert cyc/stb on the next edge.
    - Increment words_done_o.
    - Advance the address by ADDR_STEP; the address wraps modulo 2^32.
    - If words_done_o+1 == the latched count, go to DONE; otherwise go to FETCH.
  - Throughput: minimum 2 cycles per word (one accept cycle, one bus cycle with zero-wait ack).
- Timeout:
  - A cycle counter is cleared on entry to WRITE and increments each WRITE cycle without ack.
  - When it reaches TIMEOUT_CYCLES, drop cyc/stb, set error_o and go to ERR.
  - An ack on the same cycle the timeout is reached counts as success.
- DONE: done_o is high for exactly one cycle (the cycle the FSM is in DONE), then the FSM returns to IDLE.
- ERR: holds error_o and words_done_o until start_i.
- abort_i (any state except IDLE/DONE, highest priority over ack, valid and timeout):
  - Next cycle: cyc/stb = 0, FSM = ERR, error_o = 1.
  - words_done_o excludes a write acked in the abort cycle.
  - abort_i in IDLE has no effect.
- start_i while busy_o is ignored.
- Asynchronous reset mid-transfer:
  - cyc/stb drop immediately (asynchronously).
  - The job is lost; no done_o pulse.
- wbm_ack_i outside WRITE is ignored.

Test Plan:
- Reset/idle: hold wb_rst_ni low mid-WRITE → cyc/stb/done_o/error_o read 0 during reset; IDLE after release; an ack arriving in IDLE leaves words_done_o = 0.
- Basic load:
  - Stimulus: base 0x3000_0000, count 3, data A1/B2/C3 always valid, ack on the first stb cycle.
  - Response: writes to 0x3000_0000, 0x3000_0004 and 0x3000_0008 with sel 4'hF; done_o pulses once; words_done_o = 3; 6 cycles from the first FETCH to DONE.
- Backpressure:
  - Stimulus: cfg_valid_i gapped by 5 cycles; ack delayed by 3 cycles.
  - Response: adr/dat stable throughout each stb; no write issued without valid; words_done_o increments only on ack.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES = 8, count 2, the second write never acked.
  - Response: cyc drops after 8 WRITE cycles; error_o = 1; words_done_o = 1; a new start clears error_o.
- Abort/edge cases:
  - Abort asserted in the same cycle as ack → ERR with words_done_o not incremented.
  - count 0 → done_o pulses with no cyc.
  - base 0xFFFF_FFFC, count 2 → second address is 0x0000_0000.
